// File: rtl/sparc_ifu_icrdctl_pkg.sv
// Shared types and constants for the icache diagnostic/MBIST read controller.
package sparc_ifu_icrdctl_pkg;

   localparam int unsigned WAY_W  = 2;
   localparam int unsigned DATA_W = 68;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WAIT = 2'd2,
      ST_CAPT = 2'd3
   } state_e;

   localparam logic REQ_ASI  = 1'b0;
   localparam logic REQ_BIST = 1'b1;

   localparam logic [WAY_W-1:0] WAY_LAST = 2'd3;

endpackage

// File: rtl/sparc_ifu_icrdarb.sv
// Two-requester round-robin arbiter; the last-grant flop resets to ASI so MBIST
// wins the first contention.
module sparc_ifu_icrdarb
   import sparc_ifu_icrdctl_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic req_asi_i,
   input  logic req_bist_i,
   output logic gnt_asi_o,
   output logic gnt_bist_o
);

   logic last_q, last_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) last_q <= REQ_ASI;
      else       last_q <= last_d;
   end

   always_comb begin
      gnt_bist_o = en_i & req_bist_i & (~req_asi_i | (last_q == REQ_ASI));
      gnt_asi_o  = en_i & req_asi_i & ~gnt_bist_o;
      last_d     = last_q;
      if (gnt_bist_o)     last_d = REQ_BIST;
      else if (gnt_asi_o) last_d = REQ_ASI;
   end

endmodule

// File: rtl/sparc_ifu_icrdctl.sv
// Icache diagnostic read controller: serves ASI single-way reads and MBIST
// way sweeps through one shared read/capture pipeline.
module sparc_ifu_icrdctl
   import sparc_ifu_icrdctl_pkg::*;
#(
   parameter int unsigned IDX_W  = 10,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                rclk,
   input  logic                arst,
   input  logic                asi_req_vld,
   input  logic [IDX_W-1:0]    asi_req_index,
   input  logic [WAY_W-1:0]    asi_req_way,
   output logic                asi_req_rdy,
   output logic                asi_rsp_vld,
   input  logic                bist_req_vld,
   input  logic [IDX_W-1:0]    bist_req_index,
   input  logic [WAY_W-1:0]    bist_req_way,
   input  logic                bist_req_allway,
   output logic                bist_req_rdy,
   output logic                bist_rsp_vld,
   output logic [WAY_W-1:0]    rsp_way,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                ic_rd_en,
   output logic [IDX_W-1:0]    ic_rd_index,
   output logic [WAY_W-1:0]    ifq_erb_asiway_f,
   input  logic [DATA_W-1:0]   wsel_mbist_icache_data,
   output logic                busy
);

   // WAIT spans RD_LAT-1 cycles; unreachable when RD_LAT==1
   localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WAY_W-1:0]    way_q, way_d;
   logic                owner_q, owner_d;
   logic                allway_q, allway_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic [WAY_W-1:0]    rsp_way_q, rsp_way_d;
   logic                asi_rsp_q, asi_rsp_d;
   logic                bist_rsp_q, bist_rsp_d;
   logic                idle, gnt_asi, gnt_bist, sweep_more;

   assign idle       = (state_q == ST_IDLE) & ~arst;
   assign sweep_more = allway_q & (way_q != WAY_LAST);

   sparc_ifu_icrdarb u_arb (
      .clk_i      (rclk),
      .rst_i      (arst),
      .en_i       (idle),
      .req_asi_i  (asi_req_vld),
      .req_bist_i (bist_req_vld),
      .gnt_asi_o  (gnt_asi),
      .gnt_bist_o (gnt_bist)
   );

   always_ff @(posedge rclk or posedge arst) begin
      if (arst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (gnt_asi | gnt_bist) state_d = ST_RD;
         ST_RD:   state_d = (RD_LAT > 1) ? ST_WAIT : ST_CAPT;
         ST_WAIT: if (cnt_q == WAIT_LAST) state_d = ST_CAPT;
         ST_CAPT: state_d = sweep_more ? ST_RD : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ic_rd_en         = (state_q == ST_RD);
      busy             = (state_q != ST_IDLE);
      ifq_erb_asiway_f = busy ? way_q : '0;
   end

   // Request latch, wait counter, capture and response strobes
   always_comb begin
      idx_d      = idx_q;
      way_d      = way_q;
      owner_d    = owner_q;
      allway_d   = allway_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_way_d  = rsp_way_q;
      asi_rsp_d  = 1'b0;
      bist_rsp_d = 1'b0;
      if (gnt_bist) begin
         idx_d    = bist_req_index;
         way_d    = bist_req_way;
         owner_d  = REQ_BIST;
         allway_d = bist_req_allway;
      end else if (gnt_asi) begin
         idx_d    = asi_req_index;
         way_d    = asi_req_way;
         owner_d  = REQ_ASI;
         allway_d = 1'b0;
      end
      case (state_q)
         ST_RD:   cnt_d = '0;
         ST_WAIT: cnt_d = cnt_q + 2'd1;
         ST_CAPT: begin
            rsp_data_d = wsel_mbist_icache_data;
            rsp_way_d  = way_q;
            asi_rsp_d  = (owner_q == REQ_ASI);
            bist_rsp_d = (owner_q == REQ_BIST);
            if (sweep_more) way_d = way_q + 2'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge rclk or posedge arst) begin
      if (arst) begin
         idx_q      <= '0;
         way_q      <= '0;
         owner_q    <= REQ_ASI;
         allway_q   <= 1'b0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_way_q  <= '0;
         asi_rsp_q  <= 1'b0;
         bist_rsp_q <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         way_q      <= way_d;
         owner_q    <= owner_d;
         allway_q   <= allway_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_way_q  <= rsp_way_d;
         asi_rsp_q  <= asi_rsp_d;
         bist_rsp_q <= bist_rsp_d;
      end
   end

   assign asi_req_rdy  = gnt_asi;
   assign bist_req_rdy = gnt_bist;
   assign asi_rsp_vld  = asi_rsp_q;
   assign bist_rsp_vld = bist_rsp_q;
   assign rsp_way      = rsp_way_q;
   assign rsp_data     = rsp_data_q;
   assign ic_rd_index  = idx_q;

endmodule

// File: doc/sparc_ifu_icrdctl.md
SPARC_IFU_ICRDCTL -- requirements
Module: sparc_ifu_icrdctl

Interface
REQ-001 Parameter IDX_W, default 10: icache read index width.
REQ-002 Parameter RD_LAT, default 2, legal 1..4: cycles from ic_rd_en to valid wsel_mbist_icache_data.
REQ-003 Clock and reset: one clock, reset asynchronous active-high.
REQ-004 rclk  in  1  sole clock, all flops rising edge.
REQ-005 arst  in  1  asynchronous active-high reset.
REQ-006 asi_req_vld  in  1  ASI diagnostic read request.
REQ-007 asi_req_index  in  IDX_W  ASI read index.
REQ-008 asi_req_way  in  2  ASI way to read.
REQ-009 asi_req_rdy  out  1  ASI request accepted this cycle.
REQ-010 asi_rsp_vld  out  1  one-cycle ASI response strobe.
REQ-011 bist_req_vld  in  1  MBIST read request.
REQ-012 bist_req_index  in  IDX_W  MBIST read index.
REQ-013 bist_req_way  in  2  MBIST start way.
REQ-014 bist_req_allway  in  1  sweep from start way up to way 3.
REQ-015 bist_req_rdy  out  1  MBIST request accepted this cycle.
REQ-016 bist_rsp_vld  out  1  one-cycle MBIST response strobe, one per way.
REQ-017 rsp_way  out  2  way of current response.
REQ-018 rsp_data  out  68  registered captured way data, shared by both requesters.
REQ-019 ic_rd_en  out  1  icache diagnostic read enable.
REQ-020 ic_rd_index  out  IDX_W  icache read index.
REQ-021 ifq_erb_asiway_f  out  2  way select to way-select datapath.
REQ-022 wsel_mbist_icache_data  in  68  way-selected data from datapath.
REQ-023 busy  out  1  high in any state except IDLE.

Function
REQ-024 FSM states IDLE, RD, WAIT, CAPT; IDLE->RD on accept; RD->WAIT if RD_LAT>1 else CAPT; WAIT held RD_LAT-1 cycles total, then CAPT; CAPT->RD if allway sweep and way<3 (way+1), else IDLE.
REQ-025 Accept only in IDLE: rdy asserted combinationally in same cycle as winning vld; payload latched on that edge.
REQ-026 Both vld in IDLE: round-robin, last-granted flop resets to ASI so MBIST wins first contention; single requester always wins.
REQ-027 Requesters hold vld and payload stable until rdy; no rdy outside IDLE.
REQ-028 ic_rd_en high exactly one cycle, in RD; ic_rd_index equals latched index in RD.
REQ-029 ifq_erb_asiway_f holds latched way from RD through CAPT inclusive; 2'b00 in IDLE.
REQ-030 CAPT samples wsel_mbist_icache_data into rsp_data; owner's rsp_vld and rsp_way asserted the following cycle for one cycle.
REQ-031 Latency: accept cycle T -> rsp_vld at T+RD_LAT+2; sweep responses spaced RD_LAT+1 cycles.
REQ-032 ASI requests ignore allway; single-way only.
REQ-033 Allway with start way 3: single read, no wrap to 0.
REQ-034 rsp_data holds last captured value until next CAPT.
REQ-035 New accept legal in cycle of rsp_vld (FSM already IDLE).

Reset
REQ-036 arst forces IDLE, clears latched index/way/owner, last-grant to ASI.
REQ-037 During reset all outputs 0: rdy, rsp_vld, ic_rd_en, busy, rsp_way, rsp_data, ic_rd_index, ifq_erb_asiway_f.
REQ-038 Reset mid-operation aborts transaction; no response issued for it after release.

Structure
REQ-039 Shared package holds FSM state encoding, way width (2), data width (68), requester-id constants.
REQ-040 One sub-module natural: sparc_ifu_icrdarb (2-way round-robin arbiter); rest flat.

Verification
REQ-041 ASI req idx 0x155 way 2, data 68'hA5 at CAPT -> rdy at T, ic_rd_en T+1, asiway_f=2 T+1..T+3, asi_rsp_vld T+4, rsp_data 68'hA5, rsp_way 2.
REQ-042 MBIST allway way 0, data = way number -> four bist_rsp_vld at T+4,+7,+10,+13, rsp_way 0..3, busy low at T+13.
REQ-043 Both vld same cycle twice back-to-back -> MBIST granted first, ASI second.
REQ-044 arst asserted during WAIT -> all outputs 0 immediately, no rsp_vld after release, next request served normally.
REQ-045 RD_LAT=1, MBIST allway way 3 -> one read, bist_rsp_vld at T+3, rsp_way 3, no wrap.
REQ-046 ASI vld held during MBIST sweep -> asi_req_rdy stays 0 until IDLE, then ASI accepted in the rsp_vld cycle.
